// File: rtl/text_buffer_writer.sv
// Terminal-style character buffer feeding the text overlay stage.
// Byte stream in over valid/ready; scroll and clear sweep one cell per cycle.
module text_buffer_writer #(
    parameter int          COLUMNS    = 16,
    parameter int          ROWS       = 19,
    parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic [7:0]                           i_data,
    input  logic                                 i_valid,
    output logic                                 o_ready,
    output logic [ROWS*COLUMNS-1:0][7:0]         o_characters,
    output logic [$clog2(COLUMNS)-1:0]           o_cursor_x,
    output logic [$clog2(ROWS)-1:0]              o_cursor_y,
    output logic                                 o_busy
);

    localparam int NUM_CHAR = ROWS * COLUMNS;
    localparam int PW       = $clog2(NUM_CHAR + 1);
    localparam int XW       = $clog2(COLUMNS);
    localparam int YW       = $clog2(ROWS);

    localparam logic [PW-1:0] LAST_P  = PW'(NUM_CHAR - 1);
    localparam logic [PW-1:0] SHIFT_N = PW'(NUM_CHAR - COLUMNS);
    localparam logic [PW-1:0] COLS_P  = PW'(COLUMNS);
    localparam logic [XW-1:0] XMAX    = XW'(COLUMNS - 1);
    localparam logic [YW-1:0] YMAX    = YW'(ROWS - 1);

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    generate
        if (COLUMNS < 2 || ROWS < 2) begin : g_bad_geometry
            $error("text_buffer_writer: COLUMNS and ROWS must both be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        SCROLL,
        CLEAR
    } state_e;

    state_e         state_q, state_d;
    logic [PW-1:0]  k_q, k_d;
    logic [PW-1:0]  p_q, p_d;
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;

    logic [7:0]     cells_q [NUM_CHAR];

    logic           we;
    logic [PW-1:0]  waddr;
    logic [7:0]     wdata;
    logic [PW-1:0]  src;

    assign o_ready    = (state_q == IDLE);
    assign o_busy     = !o_ready;
    assign o_cursor_x = x_q;
    assign o_cursor_y = y_q;

    // Source index is only meaningful below the last row; guard keeps it in range.
    assign src = (k_q < SHIFT_N) ? (k_q + COLS_P) : k_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            p_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            p_q     <= p_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        p_d     = p_q;
        x_d     = x_q;
        y_d     = y_q;
        we      = 1'b0;
        waddr   = p_q;
        wdata   = BLANK_CHAR;

        unique case (state_q)
            IDLE: begin
                if (i_valid) begin
                    unique case (i_data)
                        CH_CR: begin
                            p_d = p_q - PW'(x_q);
                            x_d = '0;
                        end
                        CH_LF: begin
                            x_d = '0;
                            if (y_q != YMAX) begin
                                p_d = p_q - PW'(x_q) + COLS_P;
                                y_d = y_q + 1'b1;
                            end else begin
                                state_d = SCROLL;
                                k_d     = '0;
                                p_d     = SHIFT_N;
                            end
                        end
                        CH_BS: begin
                            if (p_q != '0) begin
                                p_d   = p_q - 1'b1;
                                we    = 1'b1;
                                waddr = p_q - 1'b1;
                                if (x_q == '0) begin
                                    x_d = XMAX;
                                    y_d = y_q - 1'b1;
                                end else begin
                                    x_d = x_q - 1'b1;
                                end
                            end
                        end
                        CH_FF: begin
                            state_d = CLEAR;
                            k_d     = '0;
                            p_d     = '0;
                            x_d     = '0;
                            y_d     = '0;
                        end
                        default: begin
                            we    = 1'b1;
                            wdata = i_data;
                            if (p_q == LAST_P) begin
                                state_d = SCROLL;
                                k_d     = '0;
                                p_d     = SHIFT_N;
                                x_d     = '0;
                                y_d     = YMAX;
                            end else begin
                                p_d = p_q + 1'b1;
                                if (x_q == XMAX) begin
                                    x_d = '0;
                                    y_d = y_q + 1'b1;
                                end else begin
                                    x_d = x_q + 1'b1;
                                end
                            end
                        end
                    endcase
                end
            end
            SCROLL: begin
                we    = 1'b1;
                waddr = k_q;
                wdata = (k_q < SHIFT_N) ? cells_q[src] : BLANK_CHAR;
                if (k_q == LAST_P) begin
                    state_d = IDLE;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            CLEAR: begin
                we    = 1'b1;
                waddr = k_q;
                if (k_q == LAST_P) begin
                    state_d = IDLE;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_CHAR; i++) begin
                cells_q[i] <= BLANK_CHAR;
            end
        end else if (we) begin
            cells_q[waddr] <= wdata;
        end
    end

    // Position 0 (top-left) lands in the most-significant byte.
    always_comb begin
        for (int i = 0; i < NUM_CHAR; i++) begin
            o_characters[NUM_CHAR-1-i] = cells_q[i];
        end
    end

endmodule

// File: tb/tb_text_buffer_writer.sv
// Self-checking bench for text_buffer_writer against a screen-level model.
// Random and directed byte streams, scroll/clear timing, async reset.
module tb_text_buffer_writer;

    localparam int COLS = 16;
    localparam int ROWS = 19;
    localparam int N    = COLS * ROWS;

    logic                   clk;
    logic                   rst_n;
    logic [7:0]             data;
    logic                   valid;
    logic                   ready;
    logic [N-1:0][7:0]      chars;
    logic [3:0]             cx;
    logic [4:0]             cy;
    logic                   busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] m [N];
    int         mp;

    text_buffer_writer #(.COLUMNS(COLS), .ROWS(ROWS), .BLANK_CHAR(8'h20)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_data       (data),
        .i_valid      (valid),
        .o_ready      (ready),
        .o_characters (chars),
        .o_cursor_x   (cx),
        .o_cursor_y   (cy),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) m[i] = 8'h20;
        mp = 0;
    endfunction

    function automatic void model_scroll();
        for (int i = 0; i < N; i++) m[i] = (i + COLS < N) ? m[i + COLS] : 8'h20;
        mp = (ROWS - 1) * COLS;
    endfunction

    // Returns 1 when the byte starts a multi-cycle sweep.
    function automatic bit model_apply(logic [7:0] b);
        bit sweep = 0;
        case (b)
            8'h0D: mp = (mp / COLS) * COLS;
            8'h0A: begin
                if (mp / COLS < ROWS - 1) mp = (mp / COLS + 1) * COLS;
                else begin model_scroll(); sweep = 1; end
            end
            8'h08: if (mp > 0) begin mp = mp - 1; m[mp] = 8'h20; end
            8'h0C: begin model_reset(); sweep = 1; end
            default: begin
                m[mp] = b;
                if (mp < N - 1) mp = mp + 1;
                else begin model_scroll(); sweep = 1; end
            end
        endcase
        return sweep;
    endfunction

    function automatic int screen_diff();
        for (int p = 0; p < N; p++)
            if (chars[N-1-p] !== m[p]) return p;
        return -1;
    endfunction

    function automatic logic [7:0] printable();
        logic [7:0] b;
        do b = 8'($urandom); while (b == 8'h08 || b == 8'h0A || b == 8'h0C || b == 8'h0D);
        return b;
    endfunction

    task automatic do_reset();
        valid = 1'b0;
        data  = 8'h00;
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, output bit sweep);
        int t = 0;
        @(negedge clk);
        while (ready !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
        if (t >= 2000) begin
            errors++;
            $display("FAIL send_wait: o_ready=%b stuck, required 1", ready);
        end
        valid = 1'b1;
        data  = b;
        @(posedge clk);
        sweep = model_apply(b);
        #1;
        valid = 1'b0;
    endtask

    task automatic wait_idle(output int lowcnt);
        lowcnt = 0;
        while (ready !== 1'b1 && lowcnt < 2000) begin
            lowcnt++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_state(input string name);
        int d;
        logic [3:0] ex;
        logic [4:0] ey;
        ex = 4'(mp % COLS);
        ey = 5'(mp / COLS);
        d  = screen_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL %s screen: cell %0d got %h, required %h", name, d, chars[N-1-d], m[d]);
        end
        checks++;
        if ({cx, cy} !== {ex, ey}) begin
            errors++;
            $display("FAIL %s cursor: got (%0d,%0d), required (%0d,%0d)", name, cx, cy, ex, ey);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        check_state("reset");
        checks++;
        if ({ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL reset_hs: ready/busy=%b%b, required 10", ready, busy);
        end
    endtask

    task automatic test_hi();
        bit s;
        @(negedge clk);
        valid = 1'b1; data = 8'h48;
        @(posedge clk); s = model_apply(8'h48); #1;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL hi_ready1: got %b, required 1", ready);
        end
        @(negedge clk);
        data = 8'h69;
        @(posedge clk); s = model_apply(8'h69); #1;
        valid = 1'b0;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL hi_ready2: got %b, required 1", ready);
        end
        checks++;
        if ({chars[303], chars[302]} !== 16'h4869) begin
            errors++;
            $display("FAIL hi_cells: got %h%h, required 4869", chars[303], chars[302]);
        end
        check_state("hi");
    endtask

    task automatic test_wrap_cr_bs();
        bit s;
        do_reset();
        for (int i = 0; i < 17; i++) send_byte(8'h41, s);
        check_state("wrap17");
        send_byte(8'h0D, s);
        check_state("cr");
        send_byte(8'h08, s);
        check_state("bs_cross");
        send_byte(8'h0D, s);
        send_byte(8'h0A, s);
        for (int i = 0; i < 20; i++) send_byte(8'h08, s);
        check_state("bs_at_zero");
    endtask

    task automatic fill_and_scroll(input string name);
        bit s;
        int low;
        for (int p = mp; p < N; p++) send_byte(8'h30 + 8'(p % 64), s);
        checks++;
        if (!s) begin
            errors++;
            $display("FAIL %s model: sweep=0, required 1", name);
        end
        wait_idle(low);
        checks++;
        if (low != N) begin
            errors++;
            $display("FAIL %s low_cycles: got %0d, required %0d", name, low, N);
        end
        check_state(name);
    endtask

    task automatic test_fill_scroll();
        do_reset();
        fill_and_scroll("fill_scroll");
    endtask

    task automatic test_lf();
        bit s;
        int low;
        send_byte(8'h0A, s);
        wait_idle(low);
        checks++;
        if (low != N) begin
            errors++;
            $display("FAIL lf18_low: got %0d, required %0d", low, N);
        end
        check_state("lf18");
        do_reset();
        for (int i = 0; i < 3; i++) send_byte(8'h0A, s);
        send_byte(8'h5B, s);
        send_byte(8'h0A, s);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL lf3_ready: got %b, required 1", ready);
        end
        check_state("lf3");
    endtask

    task automatic test_ff();
        bit s;
        int cnt;
        do_reset();
        for (int p = 0; p < N - 1; p++) send_byte(printable(), s);
        check_state("ff_pre");
        send_byte(8'h0C, s);
        valid = 1'b1;
        data  = 8'h5A;
        cnt   = 0;
        while (busy === 1'b1 && cnt < 2000) begin
            cnt++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (cnt != N) begin
            errors++;
            $display("FAIL ff_busy: got %0d cycles, required %0d", cnt, N);
        end
        check_state("ff_clear");
        @(posedge clk);
        s = model_apply(8'h5A);
        #1;
        valid = 1'b0;
        check_state("ff_pending");
    endtask

    task automatic test_reset_mid_scroll();
        do_reset();
        fill_and_scroll("pre_rst");
        for (int p = mp; p < N; p++) begin
            bit s;
            send_byte(8'h61, s);
        end
        repeat (50) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state("rst_mid");
        checks++;
        if ({ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL rst_mid_hs: ready/busy=%b%b, required 10", ready, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        bit s;
        int low;
        logic [7:0] b;
        do_reset();
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 19))
                0, 1:    b = 8'h0D;
                2, 3, 4: b = 8'h0A;
                5, 6:    b = 8'h08;
                7:       b = ($urandom_range(0, 3) == 0) ? 8'h0C : printable();
                default: b = printable();
            endcase
            send_byte(b, s);
            if (s) begin
                wait_idle(low);
                checks++;
                if (low != N) begin
                    errors++;
                    $display("FAIL rand_sweep: byte %h low %0d, required %0d", b, low, N);
                end
            end
            check_state("random");
        end
    endtask

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        data  = 8'h00;
        model_reset();
        #12;
        rst_n = 1'b1;
        test_reset();
        test_hi();
        test_wrap_cr_bs();
        test_fill_scroll();
        test_lf();
        test_ff();
        test_reset_mid_scroll();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
